// File: rtl/rr_merge_arb4.sv
// rr_merge_arb4: four-way round-robin merge of level request/completion handshakes
// onto one downstream stage, holding the granted payload until the completion pulse.
module rr_merge_arb4 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_drive0,
    input  logic                  i_drive1,
    input  logic                  i_drive2,
    input  logic                  i_drive3,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [DATA_WIDTH-1:0] i_data2,
    input  logic [DATA_WIDTH-1:0] i_data3,
    input  logic [3:0]            i_mask,
    output logic                  o_free0,
    output logic                  o_free1,
    output logic                  o_free2,
    output logic                  o_free3,
    output logic                  o_driveNext,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_freeNext,
    output logic [1:0]            o_grantId,
    output logic                  o_busy
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    state_t                r_state;
    logic [1:0]            r_ptr;
    logic [1:0]            r_grant;
    logic [DATA_WIDTH-1:0] r_data;
    logic [3:0]            r_free;
    logic                  r_drive;
    logic [3:0]            w_req;
    logic [3:0]            w_rot;
    logic [1:0]            w_off;
    logic [1:0]            w_win;
    logic [DATA_WIDTH-1:0] w_data;
    assign w_req = {i_drive3, i_drive2, i_drive1, i_drive0} & ~i_mask;
    // Rotate requests so bit 0 is the requester at ptr; 2-bit index sums wrap mod 4.
    for (genvar g = 0; g < 4; g++) begin : g_rot
        assign w_rot[g] = w_req[r_ptr + 2'(g)];
    end
    always_comb begin
        w_off  = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
        w_win  = r_ptr + w_off;
        w_data = w_win == 2'd0 ? i_data0 : w_win == 2'd1 ? i_data1 :
                 w_win == 2'd2 ? i_data2 : i_data3;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_data  <= '0;
            r_free  <= '0;
            r_drive <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (|w_req) begin
                    r_grant <= w_win;
                    r_data  <= w_data;
                    r_drive <= 1'b1;
                    r_state <= BUSY;
                end
                BUSY: if (i_freeNext) begin
                    r_ptr   <= r_grant + 2'd1;
                    r_free  <= 4'b0001 << r_grant;
                    r_drive <= 1'b0;
                    r_state <= RELEASE;
                end
                default: begin
                    r_free  <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
    assign o_free0     = r_free[0];
    assign o_free1     = r_free[1];
    assign o_free2     = r_free[2];
    assign o_free3     = r_free[3];
    assign o_driveNext = r_drive;
    assign o_data      = r_data;
    assign o_grantId   = r_grant;
    assign o_busy      = r_state != IDLE;
endmodule

// File: tb/tb_rr_merge_arb4.sv
// tb_rr_merge_arb4: directed stimulus for rr_merge_arb4, checked every cycle against
// a transaction-level model plus hand-computed literal expectations.
module tb_rr_merge_arb4;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  drv = '0;
    logic [31:0] dat [4];
    logic [3:0]  mask = '0;
    logic        free_next = 1'b0;
    logic        o_free0, o_free1, o_free2, o_free3, o_driveNext, o_busy;
    logic [31:0] o_data;
    logic [1:0]  o_grantId;
    int errors = 0;
    int checks = 0;

    rr_merge_arb4 #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .i_drive0(drv[0]), .i_drive1(drv[1]), .i_drive2(drv[2]), .i_drive3(drv[3]),
        .i_data0(dat[0]), .i_data1(dat[1]), .i_data2(dat[2]), .i_data3(dat[3]),
        .i_mask(mask),
        .o_free0(o_free0), .o_free1(o_free1), .o_free2(o_free2), .o_free3(o_free3),
        .o_driveNext(o_driveNext), .o_data(o_data), .i_freeNext(free_next),
        .o_grantId(o_grantId), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 = waiting for a winner, 1 = transfer open, 2 = completion cycle.
    int          m_st = 0;
    int          m_ptr = 0;
    int          m_gid = 0;
    logic [31:0] m_data = '0;

    function automatic int pick(input logic [3:0] elig, input int ptr);
        for (int k = 0; k < 4; k++)
            if (elig[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_st <= 0; m_ptr <= 0; m_gid <= 0; m_data <= '0;
        end else if (m_st == 0) begin
            if (pick(drv & ~mask, m_ptr) >= 0) begin
                m_gid  <= pick(drv & ~mask, m_ptr);
                m_data <= dat[pick(drv & ~mask, m_ptr)];
                m_st   <= 1;
            end
        end else if (m_st == 1) begin
            if (free_next) begin
                m_ptr <= (m_gid + 1) % 4;
                m_st  <= 2;
            end
        end else m_st <= 0;
    end

    always @(negedge clk) begin
        chk("model_drive", o_driveNext, m_st == 1);
        chk("model_busy", o_busy, m_st != 0);
        chk("model_gid", o_grantId, m_gid);
        chk("model_data", o_data, m_data);
        chk("model_free", {o_free3, o_free2, o_free1, o_free0}, m_st == 2 ? (4'b1 << m_gid) : 4'b0);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_drive();
        int t = 0;
        while (!o_driveNext && t < 10) begin cyc(1); t++; end
        chk("wait_drive", o_driveNext, 1);
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) dat[i] = '0;
        #1;
        chk("rst_drive", o_driveNext, 0);
        chk("rst_free", {o_free3, o_free2, o_free1, o_free0}, 0);
        chk("rst_data", o_data, 0);
        cyc(2);
        rstn = 1'b1;
        // freeNext while idle with nothing requesting
        free_next = 1'b1;
        cyc(3);
        chk("idle_free_busy", o_busy, 0);
        chk("idle_free_drive", o_driveNext, 0);
        free_next = 1'b0;
        // single request from requester 2
        drv[2] = 1'b1; dat[2] = 32'hA5A5A5A5;
        cyc(1);
        chk("single_drive", o_driveNext, 1);
        chk("single_data", o_data, 32'hA5A5A5A5);
        chk("single_gid", o_grantId, 2);
        free_next = 1'b1;
        cyc(1);
        chk("single_free", {o_free3, o_free2, o_free1, o_free0}, 4'b0100);
        chk("single_drop", o_driveNext, 0);
        drv[2] = 1'b0; free_next = 1'b0;
        cyc(1);
        chk("single_free_end", {o_free3, o_free2, o_free1, o_free0}, 4'b0000);
        // reset pointer back to 0, then all four request continuously
        rstn = 1'b0; #2; rstn = 1'b1;
        for (int i = 0; i < 4; i++) dat[i] = 32'h1000 + i;
        drv = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_drive();
            chk("rr_order", o_grantId, exp_order[i]);
            chk("rr_data", o_data, 32'h1000 + exp_order[i]);
            free_next = 1'b1;
            cyc(1);
            chk("rr_free", {o_free3, o_free2, o_free1, o_free0}, 4'b1 << exp_order[i]);
            free_next = 1'b0;
            if (i == 4) drv = '0;
            cyc(1);
        end
        // ptr is 1: masked 3 loses to 0, then unmasked 3 wins
        drv = 4'b1001; mask = 4'b1000;
        cyc(1);
        chk("mask_gid0", o_grantId, 0);
        mask = 4'b0000;
        free_next = 1'b1;
        cyc(1);
        chk("mask_free0", {o_free3, o_free2, o_free1, o_free0}, 4'b0001);
        free_next = 1'b0;
        cyc(2);
        chk("mask_gid3", o_grantId, 3);
        free_next = 1'b1; drv = '0;
        cyc(1);
        chk("mask_free3", {o_free3, o_free2, o_free1, o_free0}, 4'b1000);
        free_next = 1'b0;
        cyc(1);
        // requester 1 drops its request while the transfer is held open
        drv[1] = 1'b1; dat[1] = 32'h11112222;
        cyc(1);
        chk("hold_gid", o_grantId, 1);
        drv[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("hold_drive", o_driveNext, 1);
            chk("hold_data", o_data, 32'h11112222);
        end
        free_next = 1'b1;
        cyc(1);
        chk("hold_free", {o_free3, o_free2, o_free1, o_free0}, 4'b0010);
        free_next = 1'b0;
        cyc(1);
        // reset in the middle of a transfer
        drv[0] = 1'b1; dat[0] = 32'hDEAD0000;
        cyc(1);
        chk("rstmid_gid", o_grantId, 0);
        chk("rstmid_drive", o_driveNext, 1);
        free_next = 1'b1;
        rstn = 1'b0;
        #1;
        chk("rstmid_drive0", o_driveNext, 0);
        chk("rstmid_data0", o_data, 0);
        chk("rstmid_busy0", o_busy, 0);
        cyc(1);
        free_next = 1'b0;
        rstn = 1'b1;
        cyc(1);
        chk("rstmid_regrant", o_driveNext, 1);
        chk("rstmid_nofree", {o_free3, o_free2, o_free1, o_free0}, 4'b0000);
        chk("rstmid_regid", o_data, 32'hDEAD0000);
        free_next = 1'b1; drv = '0;
        cyc(1);
        chk("rstmid_free", {o_free3, o_free2, o_free1, o_free0}, 4'b0001);
        free_next = 1'b0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_merge_arb4.md
RR_MERGE_ARB4 -- requirements
Module: rr_merge_arb4

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of every data port.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports i_drive0..i_drive3, input, 1 bit each: level request from requester n, held until o_freen.
REQ-005 The block SHALL have ports i_data0..i_data3, input, DATA_WIDTH each: payload of requester n, stable while i_driven=1.
REQ-006 The block SHALL have port i_mask, input, 4 bits: bit n=1 excludes requester n from arbitration.
REQ-007 The block SHALL have ports o_free0..o_free3, output, 1 bit each: one-cycle completion pulse to requester n.
REQ-008 The block SHALL have port o_driveNext, output, 1 bit: level request to the shared downstream stage.
REQ-009 The block SHALL have port o_data, output, DATA_WIDTH: registered payload of the granted requester.
REQ-010 The block SHALL have port i_freeNext, input, 1 bit: downstream completion, sampled on clk.
REQ-011 The block SHALL have port o_grantId, output, 2 bits: index of the current or last granted requester.
REQ-012 The block SHALL have port o_busy, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and RELEASE.
REQ-014 The set of eligible requesters SHALL be every n with i_driven=1 and i_mask[n]=0.
REQ-015 In IDLE, when at least one requester is eligible, the winner SHALL be the first eligible index searching from ptr upward, modulo 4.
REQ-016 On that same edge, the winner's index SHALL be latched into o_grantId, its i_data into o_data, and the FSM SHALL go to BUSY.
REQ-017 o_driveNext SHALL be 1 exactly while the FSM is in BUSY, with latency 1 cycle from the sampled request to o_driveNext=1.
REQ-018 o_data and o_grantId SHALL stay constant throughout BUSY and RELEASE.
REQ-019 In BUSY, i_freeNext=1 on an edge SHALL move the FSM to RELEASE and set ptr to (o_grantId+1) mod 4.
REQ-020 In RELEASE, o_free[o_grantId] SHALL be 1 for exactly one cycle, all other o_free SHALL be 0, and the FSM SHALL go to IDLE on the next edge.
REQ-021 Timing: i_freeNext sampled at edge M gives o_driveNext=0 and the o_free pulse in cycle M+1, with the next grant possible at edge M+2.
REQ-022 i_freeNext SHALL be ignored in IDLE and RELEASE.
REQ-023 Dropping i_drive or setting i_mask for the granted requester during BUSY SHALL NOT abort the transaction, and its o_free SHALL still pulse.
REQ-024 Changes to i_mask SHALL affect only the next IDLE arbitration.
REQ-025 With no eligible requester, the block SHALL stay in IDLE with all outputs holding.
REQ-026 A requester that keeps i_drive high after its o_free pulse SHALL be treated as a new request.
REQ-027 The fairness bound SHALL be: any continuously eligible requester is granted within 4 grants.

Reset
REQ-028 rstn=0 SHALL, asynchronously, set FSM=IDLE, ptr=0, o_driveNext=0, o_free0..3=0, o_data=0, o_grantId=0 and o_busy=0.
REQ-029 Reset asserted during BUSY or RELEASE SHALL drop the transaction, with no o_free pulse after release.
REQ-030 The first arbitration SHALL happen on the first rising clk edge with rstn=1.

Verification
REQ-031 Single request: i_drive2=1, i_data2=0xA5A5A5A5 -> next cycle o_driveNext=1, o_data=0xA5A5A5A5, o_grantId=2; i_freeNext pulse -> o_free2 pulses 1 cycle, o_driveNext=0.
REQ-032 All four requesting continuously, freeNext returned 1 cycle after each driveNext -> grant order 0,1,2,3,0 and exactly one o_free per grant.
REQ-033 ptr=1 with i_drive0=i_drive3=1 and i_mask=4'b1000 -> requester 0 is granted; clearing the mask -> requester 3 wins the next arbitration (ptr=1 searches 1,2,3).
REQ-034 While granted to 1, drop i_drive1 and hold i_freeNext=0 for 10 cycles -> o_driveNext stays 1 and o_data stays stable; i_freeNext=1 -> o_free1 still pulses.
REQ-035 rstn=0 mid-BUSY -> all outputs 0 immediately; after release, no o_free pulse; a pending i_drive0=1 is granted 1 cycle after the first edge with rstn=1.
REQ-036 i_freeNext=1 while IDLE with no request -> no output change and o_busy stays 0.
